// File: rtl/dw_div_sat_pkg.sv
// Shared types and saturation limits for dw_div_sat_seq.
// Limit functions return 64-bit patterns; callers slice to width.
package dw_div_sat_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic [63:0] ones_f(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] max_pos_f(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_neg_f(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/dw_div_sat_step.sv
// One restoring-division step on magnitudes.
// Shifts in one dividend bit, subtracts divisor if it fits.
module dw_div_sat_step #(
  parameter int B_WIDTH = 8
) (
  input  logic [B_WIDTH-1:0] rem_i,
  input  logic               bit_i,
  input  logic [B_WIDTH-1:0] dvs_i,
  output logic [B_WIDTH-1:0] rem_o,
  output logic               q_o
);

  logic [B_WIDTH:0] sh;
  logic [B_WIDTH:0] diff;

  // trial subtract; a clear sign bit means the divisor fits
  always_comb begin
    sh    = {rem_i, bit_i};
    diff  = sh - {1'b0, dvs_i};
    q_o   = ~diff[B_WIDTH];
    rem_o = q_o ? diff[B_WIDTH-1:0] : sh[B_WIDTH-1:0];
  end

endmodule

// File: rtl/dw_div_sat_seq.sv
// Sequential saturating divider, unsigned or two's complement.
// Optional DW_DIV_SAT_SEQ_EARLY_SAT_EN skips BUSY on overflow.
module dw_div_sat_seq
  import dw_div_sat_pkg::*;
#(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 8,
  parameter int Q_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               tc_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Q_WIDTH-1:0] quotient,
  output logic [B_WIDTH-1:0] remainder,
  output logic               sat,
  output logic               div_by_zero
);

  localparam int CW = $clog2(A_WIDTH + 1);
  localparam int EW = A_WIDTH + Q_WIDTH;
  localparam logic [63:0] ONES_Q = ones_f(Q_WIDTH);
  localparam logic [63:0] MAXP_Q = max_pos_f(Q_WIDTH);
  localparam logic [63:0] MINN_Q = min_neg_f(Q_WIDTH);

  state_e state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [A_WIDTH-1:0] dvd_q, dvd_d;
  logic [B_WIDTH-1:0] rem_q, rem_d;
  logic [B_WIDTH-1:0] dvs_q, dvs_d;
  logic tc_q, tc_d, nega_q, nega_d, negq_q, negq_d;
  logic zero_q, zero_d, ovf_q, ovf_d;
  logic [Q_WIDTH-1:0] quo_q, quo_d;
  logic [B_WIDTH-1:0] rmd_q, rmd_d;
  logic sat_q, sat_d, dz_q, dz_d;

  logic               a_neg, b_neg, early;
  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;
  logic [B_WIDTH-1:0] step_rem;
  logic               step_q;
  logic [A_WIDTH-1:0] lim, q_full;
  logic [B_WIDTH-1:0] r_full;
  logic [Q_WIDTH-1:0] q_sat;
  logic               fix_ovf, sel_neg;

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign sat         = sat_q;
  assign div_by_zero = dz_q;

  // operand magnitudes at the input
  always_comb begin
    a_neg = tc_mode & a[A_WIDTH-1];
    b_neg = tc_mode & b[B_WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

`ifdef DW_DIV_SAT_SEQ_EARLY_SAT_EN
  // quotient magnitude >= 2^Q overflows in every mode
  always_comb begin
    early = (b != '0) &&
            (EW'(a_mag) >= (EW'(b_mag) << Q_WIDTH));
  end
`else
  assign early = 1'b0;
`endif

  dw_div_sat_step #(
    .B_WIDTH(B_WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .bit_i(dvd_q[A_WIDTH-1]),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );

  // sign correction and saturation limits for FIX
  always_comb begin
    if (!tc_q)
      lim = ONES_Q[A_WIDTH-1:0];
    else if (negq_q)
      lim = MINN_Q[A_WIDTH-1:0];
    else
      lim = MAXP_Q[A_WIDTH-1:0];
    fix_ovf = ovf_q | (dvd_q > lim);
    sel_neg = zero_q ? nega_q : negq_q;
    if (!tc_q)
      q_sat = ONES_Q[Q_WIDTH-1:0];
    else if (sel_neg)
      q_sat = MINN_Q[Q_WIDTH-1:0];
    else
      q_sat = MAXP_Q[Q_WIDTH-1:0];
    q_full = negq_q ? -dvd_q : dvd_q;
    r_full = nega_q ? -rem_q : rem_q;
  end

  // next state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    tc_d    = tc_q;
    nega_d  = nega_q;
    negq_d  = negq_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    sat_d   = sat_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tc_d   = tc_mode;
          nega_d = a_neg;
          negq_d = a_neg ^ b_neg;
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          rem_d  = '0;
          cnt_d  = '0;
          zero_d = (b == '0);
          ovf_d  = early;
          if ((b == '0) || early)
            state_d = S_FIX;
          else
            state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(A_WIDTH)) begin
          state_d = S_FIX;
        end else begin
          dvd_d = {dvd_q[A_WIDTH-2:0], step_q};
          rem_d = step_rem;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (zero_q || fix_ovf) begin
          quo_d = q_sat;
          rmd_d = '0;
          sat_d = 1'b1;
          dz_d  = zero_q;
        end else begin
          quo_d = q_full[Q_WIDTH-1:0];
          rmd_d = r_full;
          sat_d = 1'b0;
          dz_d  = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      tc_q   <= 1'b0;
      nega_q <= 1'b0;
      negq_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      quo_q  <= '0;
      rmd_q  <= '0;
      sat_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      tc_q   <= tc_d;
      nega_q <= nega_d;
      negq_q <= negq_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      sat_q  <= sat_d;
      dz_q   <= dz_d;
    end
  end

endmodule

// File: tb/tb_dw_div_sat_seq.sv
// Self-checking bench for dw_div_sat_seq (16/8/8).
// Reference model uses plain integer division.
module tb_dw_div_sat_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [7:0]  b;
  logic        tc_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        sat;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dw_div_sat_seq #(
    .A_WIDTH(16),
    .B_WIDTH(8),
    .Q_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .tc_mode    (tc_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .sat        (sat),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [15:0] ai,
                       input logic [7:0] bi,
                       input bit tci,
                       output logic [7:0] q,
                       output logic [7:0] r,
                       output logic s,
                       output logic z,
                       output int lat);
    longint sa, sb, qt, rt, lo, hi, ma, mb;
    if (tci) begin
      sa = longint'($signed(ai));
      sb = longint'($signed(bi));
    end else begin
      sa = longint'(ai);
      sb = longint'(bi);
    end
    s = 1'b0;
    z = 1'b0;
    lat = 18;
    if (sb == 0) begin
      z = 1'b1;
      s = 1'b1;
      r = 8'h00;
      lat = 1;
      if (!tci) q = 8'hFF;
      else q = (sa < 0) ? 8'h80 : 8'h7F;
    end else begin
      qt = sa / sb;
      rt = sa % sb;
      lo = tci ? -128 : 0;
      hi = tci ? 127 : 255;
      if (qt > hi) begin
        q = 8'(hi);
        r = 8'h00;
        s = 1'b1;
      end else if (qt < lo) begin
        q = 8'h80;
        r = 8'h00;
        s = 1'b1;
      end else begin
        q = 8'(qt);
        r = 8'(rt);
      end
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
`ifdef DW_DIV_SAT_SEQ_EARLY_SAT_EN
      if (ma >= mb * 256) lat = 1;
`else
      if (ma < 0 || mb < 0) lat = 0;
`endif
    end
  endtask

  task automatic do_op(input logic [15:0] ai,
                       input logic [7:0] bi,
                       input bit tci,
                       input int hold,
                       input string tag);
    logic [7:0] eq, er;
    logic es, ez;
    int elat, lat;
    model(ai, bi, tci, eq, er, es, ez, elat);
    @(negedge clk);
    a = ai;
    b = bi;
    tc_mode = tci;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_sat"}, 32'(sat), 32'(es));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = ~ai;
      b = bi + 8'd1;
      @(posedge clk);
      #1;
      check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_q"}, 32'(quotient), 32'(eq));
      check({tag, "_hold_r"}, 32'(remainder), 32'(er));
      check({tag, "_hold_s"}, {30'd0, sat, div_by_zero}, {30'd0, es, ez});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
    check({tag, "_rel_v"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tc_mode = 1'b0;
    #1;
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_v", 32'(out_valid), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_flags", {30'd0, sat, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(16'd1000, 8'd10, 1'b0, 0, "u1000_10");
    do_op(16'hFFFF, 8'd2, 1'b0, 0, "uffff_2");
    do_op(16'h8000, 8'hFF, 1'b1, 0, "tmin_m1");
    do_op(-16'sd1024, 8'd8, 1'b1, 0, "tm1024_8");
    do_op(-16'sd7, 8'd2, 1'b1, 0, "tm7_2");
    do_op(16'd5, 8'd0, 1'b0, 0, "u5_0");
    do_op(-16'sd5, 8'd0, 1'b1, 0, "tm5_0");
    do_op(16'd0, 8'd0, 1'b1, 0, "t0_0");
    do_op(16'd255, 8'd1, 1'b0, 0, "u255_1");
    do_op(16'd256, 8'd1, 1'b0, 0, "u256_1");
    do_op(16'd128, 8'hFF, 1'b1, 0, "t128_m1");
    do_op(16'd127, 8'd1, 1'b1, 0, "t127_1");
    do_op(16'd1234, 8'd77, 1'b0, 5, "hold5");

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra;
      logic [7:0] rb;
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 0)
        ra = 16'($urandom_range(0, 4095));
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        rb = 8'd0;
      do_op(ra, rb, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    a = 16'd5000;
    b = 8'd3;
    tc_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rdy", 32'(in_ready), 32'd1);
    check("mid_v", 32'(out_valid), 32'd0);
    check("mid_q", 32'(quotient), 32'd0);
    check("mid_r", 32'(remainder), 32'd0);
    check("mid_flags", {30'd0, sat, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'd1000, 8'd10, 1'b0, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
